// File: rtl/usr_pkg.sv
// Shared types for the universal-shift-register controller: mode encodings,
// FSM states, the command record and the shift-count clamp.
package usr_pkg;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    localparam int unsigned MAX_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_e;

    typedef struct packed {
        logic [3:0] data;
        logic       dir;
        logic [2:0] count;
    } cmd_t;

    // Requests beyond the register width collapse to a full-width shift.
    function automatic logic [2:0] clampCount(input logic [2:0] count);
        return (count > 3'(MAX_SHIFT)) ? 3'(MAX_SHIFT) : count;
    endfunction

endpackage

// File: rtl/usr_shift_ctrl_if.sv
// Command handshake plus the mode/data lines that drive the universal shift
// register; master is the command source, slave is the controller.
interface usr_shift_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic [2:0] cmd_count;
    logic [1:0] sel;
    logic [3:0] parin;
    logic       busy;
    logic       done;

    modport master (
        output cmd_valid,
        output cmd_data,
        output cmd_dir,
        output cmd_count,
        input  cmd_ready,
        input  sel,
        input  parin,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  cmd_dir,
        input  cmd_count,
        output cmd_ready,
        output sel,
        output parin,
        output busy,
        output done
    );

endinterface

// File: rtl/usr_cmd_fifo.sv
// DEPTH-entry command queue (DEPTH a power of two) with a registered
// occupancy count so a push and a pop in the same cycle net to zero.
module usr_cmd_fifo
    import usr_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic push_i,
    input  logic pop_i,
    input  cmd_t wdata_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    cmd_t            mem_q [DEPTH];
    logic [PtrW-1:0] wrPtr_q;
    logic [PtrW-1:0] rdPtr_q;
    logic [CntW-1:0] count_q;
    logic            doPush;
    logic            doPop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q];

    // Storage needs no reset; the cleared count marks every slot invalid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PtrW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PtrW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/usr_shift_ctrl.sv
// Sequences load/shift/hold modes for a 4-bit universal shift register.
// Define USR_CTRL_FIFO_EN to queue commands in a DEPTH-entry FIFO.
module usr_shift_ctrl
    import usr_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    usr_shift_ctrl_if.slave  bus
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("usr_shift_ctrl: DEPTH must be a power of two >= 2");
    end

    state_e     state_q;
    state_e     state_d;
    logic [2:0] shiftCnt_q;
    logic [2:0] shiftCnt_d;
    logic       dir_q;
    logic       dir_d;
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic [3:0] parin_q;
    logic [3:0] parin_d;
    logic       busy_q;
    logic       busy_d;
    logic       done_q;
    logic       done_d;

    cmd_t       cmdIn;
    cmd_t       headCmd;
    logic       bufEmpty;
    logic       cmdReady;
    logic       push;
    logic       pop;

    assign cmdIn = '{data: bus.cmd_data, dir: bus.cmd_dir, count: bus.cmd_count};
    assign push  = bus.cmd_valid && cmdReady;

`ifdef USR_CTRL_FIFO_EN
    logic bufFull;

    usr_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmdFifo (
        .clk     (clk),
        .clr     (clr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (cmdIn),
        .rdata_o (headCmd),
        .full_o  (bufFull),
        .empty_o (bufEmpty)
    );

    assign cmdReady = !bufFull;
`else
    cmd_t cmdReg_q;
    logic cmdFull_q;

    // Only accepted while idle and empty, so push and pop never coincide.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cmdReg_q  <= '0;
            cmdFull_q <= 1'b0;
        end else if (push) begin
            cmdReg_q  <= cmdIn;
            cmdFull_q <= 1'b1;
        end else if (pop) begin
            cmdFull_q <= 1'b0;
        end
    end

    assign headCmd  = cmdReg_q;
    assign bufEmpty = !cmdFull_q;
    assign cmdReady = (state_q == IDLE) && !cmdFull_q;
`endif

    always_comb begin
        state_d    = state_q;
        shiftCnt_d = shiftCnt_q;
        dir_d      = dir_q;
        parin_d    = parin_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bufEmpty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end
            end
            LOAD: begin
                state_d = (shiftCnt_q != 3'd0) ? SHIFT : DONE;
            end
            SHIFT: begin
                shiftCnt_d = shiftCnt_q - 3'd1;
                if (shiftCnt_q <= 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bufEmpty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The popped command is latched here so later bus activity cannot disturb it.
        if (pop) begin
            shiftCnt_d = clampCount(headCmd.count);
            dir_d      = headCmd.dir;
            parin_d    = headCmd.data;
        end
    end

    always_comb begin
        sel_d  = SEL_HOLD;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_d)
            LOAD:    sel_d = SEL_LOAD;
            SHIFT:   sel_d = dir_d ? SEL_LEFT : SEL_RIGHT;
            default: sel_d = SEL_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            shiftCnt_q <= 3'd0;
            dir_q      <= 1'b0;
            sel_q      <= SEL_HOLD;
            parin_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftCnt_q <= shiftCnt_d;
            dir_q      <= dir_d;
            sel_q      <= sel_d;
            parin_q    <= parin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.cmd_ready = cmdReady;
    assign bus.sel       = sel_q;
    assign bus.parin     = parin_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
